// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver feeding a small scan-code FIFO for the keyboard I/O port.
//
// Ports:
//   clk       - 50 MHz system clock; all state changes on its rising edge
//   clrn      - asynchronous active-low reset
//   ps2_clk   - raw PS/2 clock pin (asynchronous)
//   ps2_data  - raw PS/2 data pin (asynchronous)
//   rdn       - active-low read strobe; one pop per high-to-low transition
//   data      - scan code at the FIFO head, valid while ready=1
//   ready     - FIFO holds at least one code
//   overflow  - sticky: a good frame was dropped because the FIFO was full
//   frame_err - sticky: start/parity/stop error or a timeout abort
// Both sticky flags clear on a pop unless a new setting event lands in the same cycle.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rdn,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TmoW-1:0]       TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [TmoW-1:0]       TmoOne  = TmoW'(1);
  localparam logic [DEPTH_LOG2:0]   CntFull = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CntOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Input synchronizers; preset high so reset release never looks like a clock fall.
  logic [2:0] clk_sync_q, dat_sync_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data};
    end
  end

  logic fall, bit_in;
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  // Data pin settles long before the clock falls, so the oldest stage is safe to sample.
  assign bit_in = dat_sync_q[2];

  // Receiver state
  state_e          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            push, rx_err;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    tmo_d    = tmo_q;
    push     = 1'b0;
    rx_err   = 1'b0;
    if (state_q != StIdle) tmo_d = tmo_q + TmoOne;
    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!bit_in) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end else begin
            rx_err = 1'b1;
          end
        end
        StData: begin
          shreg_d  = {bit_in, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = bit_in;
          state_d  = StStop;
        end
        StStop: begin
          if (bit_in && (^{shreg_q, parity_q})) push = 1'b1;
          else rx_err = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_q == TmoLast) begin
      // Device went silent mid-frame: abandon it.
      state_d = StIdle;
      tmo_d   = '0;
      rx_err  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= StIdle;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tmo_q    <= tmo_d;
    end
  end

  // FIFO
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  rdn_q, overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic                  full, pop, do_write, drop;

  assign full     = (count_q == CntFull);
  assign pop      = rdn_q & ~rdn & (count_q != '0);
  // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    wr_ptr_d    = do_write ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d     = count_q;
    if (do_write && !pop) count_d = count_q + CntOne;
    else if (pop && !do_write) count_d = count_q - CntOne;
    overflow_d  = drop | (overflow_q & ~pop);
    frame_err_d = rx_err | (frame_err_q & ~pop);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdn_q       <= 1'b1;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (do_write) mem_q[wr_ptr_q] <= shreg_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdn_q       <= rdn;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = mem_q[rd_ptr_q];
  assign ready     = (count_q != '0);
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: a queue-based model of the scan-code FIFO and sticky flags is
// compared against the DUT on every falling clock edge; directed literals pin the model.
module tb_ps2_rx_fifo;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       clrn, ps2_clk, ps2_data, rdn;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int n_checks = 0;
  int n_errors = 0;

  ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rdn      (rdn),
    .data     (data),
    .ready    (ready),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Model: queue of accepted codes plus sticky flags; updated from events posted by stimulus.
  logic [7:0] mq[$];
  bit         m_ovf = 0, m_ferr = 0;
  bit         ev_push = 0, ev_pop = 0, ev_ferr = 0;
  logic [7:0] ev_byte = 8'h00;
  bit         chk_en = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Pop is applied before push, so a pop frees room for a same-cycle push.
  always @(posedge clk) begin
    #2;
    if (ev_pop && mq.size() > 0) begin
      void'(mq.pop_front());
      m_ovf  = 0;
      m_ferr = 0;
    end
    if (ev_push) begin
      if (mq.size() < 8) mq.push_back(ev_byte);
      else m_ovf = 1;
    end
    if (ev_ferr) m_ferr = 1;
    ev_push = 0;
    ev_pop  = 0;
    ev_ferr = 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("ready", ready, mq.size() != 0);
      if (mq.size() != 0) chk8("data", data, mq[0]);
      chk1("overflow", overflow, m_ovf);
      chk1("frame_err", frame_err, m_ferr);
    end
  end

  // One PS/2 bit cell, entered and left at a falling sys clock edge.
  // mode: 0 plain, 1 good stop (push), 2 bad stop (frame error), 3 good stop with pop.
  // The receiver acts on the third rising edge after the pin falls.
  task automatic bit_cell(input logic v, input int mode, input logic [7:0] b);
    ps2_data = v;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    if (mode == 0) begin
      repeat (10) @(negedge clk);
    end else begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      if (mode == 3) rdn = 1'b0;
      @(posedge clk);
      #1;
      if (mode == 2) ev_ferr = 1;
      else begin
        ev_push = 1;
        ev_byte = b;
      end
      if (mode == 3) ev_pop = 1;
      repeat (8) @(negedge clk);
    end
    ps2_clk = 1'b1;
    rdn     = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_on_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    bit_cell(1'b0, 0, b);
    for (int i = 0; i < 8; i++) bit_cell(b[i], 0, b);
    bit_cell(p, 0, b);
    bit_cell(1'b1, bad_par ? 2 : (pop_on_stop ? 3 : 1), b);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    bit_cell(1'b0, 0, b);
    for (int i = 0; i < n; i++) bit_cell(b[i], 0, b);
  endtask

  // Start + 3 data bits, then the PS/2 clock stays high until the timeout fires.
  task automatic timeout_frame(input logic [7:0] b);
    send_partial(b, 2);
    ps2_data = b[2];
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (TMO + 3 - 10) @(posedge clk);
    #1;
    ev_ferr = 1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_check(input logic [7:0] exp);
    chk1("pop_ready", ready, 1'b1);
    chk8("pop_data", data, exp);
    rdn = 1'b0;
    @(posedge clk);
    #1;
    ev_pop = 1;
    repeat (3) @(negedge clk);
    rdn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clrn     = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rdn      = 1'b1;
    repeat (3) @(negedge clk);
    chk8("rst_data", data, 8'h00);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    clrn   = 1'b1;
    chk_en = 1;
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame
    send_partial(8'hA5, 4);
    #2;
    clrn = 1'b0;
    mq.delete();
    m_ovf  = 0;
    m_ferr = 0;
    @(negedge clk);
    chk1("midrst_ready", ready, 1'b0);
    @(negedge clk);
    #2;
    clrn = 1'b1;
    @(negedge clk);
    send_frame(8'h1C, 0, 0);
    chk1("t1_ready", ready, 1'b1);
    chk8("t1_data", data, 8'h1C);
    chk1("t1_frame_err", frame_err, 1'b0);
    pop_check(8'h1C);
    chk1("t1_single", ready, 1'b0);

    // Make/break sequence
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    pop_check(8'h1C);
    pop_check(8'hF0);
    pop_check(8'h1C);
    chk1("t2_empty", ready, 1'b0);

    // Overflow: nine frames into eight slots
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 0, 0);
    chk1("t3_overflow", overflow, 1'b1);
    for (int k = 1; k <= 8; k++) pop_check(8'(k));
    chk1("t3_empty", ready, 1'b0);
    chk1("t3_ovf_clr", overflow, 1'b0);

    // Parity error, then a good frame
    send_frame(8'h1C, 1, 0);
    chk1("t4_ready", ready, 1'b0);
    chk1("t4_frame_err", frame_err, 1'b1);
    send_frame(8'h32, 0, 0);
    chk1("t4_ferr_held", frame_err, 1'b1);
    pop_check(8'h32);
    chk1("t4_ferr_clr", frame_err, 1'b0);

    // Timeout abort
    timeout_frame(8'hFF);
    chk1("t5_frame_err", frame_err, 1'b1);
    chk1("t5_ready", ready, 1'b0);
    send_frame(8'h5A, 0, 0);
    pop_check(8'h5A);
    chk1("t5_empty", ready, 1'b0);

    // Full FIFO with push and pop on the same cycle
    for (int k = 0; k < 8; k++) send_frame(8'h10 + 8'(k), 0, 0);
    chk8("t6_head", data, 8'h10);
    send_frame(8'hA5, 0, 1);
    chk1("t6_no_ovf", overflow, 1'b0);
    for (int k = 1; k < 8; k++) pop_check(8'h10 + 8'(k));
    pop_check(8'hA5);
    chk1("t6_empty", ready, 1'b0);

    // Pointer wrap
    for (int k = 0; k < 10; k++) begin
      send_frame(8'h40 + 8'(k), 0, 0);
      pop_check(8'h40 + 8'(k));
    end
    chk1("t7_empty", ready, 1'b0);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
